sdram_arbiter_rr: RTL and testbench

Parametrised N-client arbiter for the single SDRAM controller port, replacing the fixed per-phase state-sequenced mux. Clients (line buffer, background/DFJK, sprite/score, PCM, init) each raise read/write requests. An external scheduler supplies a per-client enable mask, and one designated high-priority client can win at every arbitration point. Arbitration is round-robin, with optional bounded burst lock. Command fields are registered, and read data and acknowledge are routed back to the granted client only.

---
 rtl/sdram_arbiter_rr_pkg.sv | 13 +
 rtl/sdram_arbiter_rr_if.sv | 28 ++
 rtl/sdram_arbiter_rr_pick.sv | 25 ++
 rtl/sdram_arbiter_rr.sv | 94 +++++++++
 tb/tb_sdram_arbiter_rr.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arbiter_rr_pkg.sv
// sdram_arb_pkg: arbiter states, command record and widths shared with the controller wrapper
package sdram_arb_pkg;
  localparam int ARB_ADDR_W = 22;
  localparam int ARB_DATA_W = 128;
  localparam int ARB_BE_W = ARB_DATA_W / 8;
  typedef enum logic [1:0] {IDLE, CMD, ACK} arb_state_t;
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wrdata;
    logic [ARB_BE_W-1:0]   be;
    logic                  wr;
  } arb_cmd_t;
endpackage

// File: rtl/sdram_arbiter_rr_if.sv
// sdram_arbiter_rr_if: client request/response bundle plus the SDRAM controller command port
interface sdram_arbiter_rr_if import sdram_arb_pkg::*; #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW = $clog2(NUM_CLIENTS);
  logic [NUM_CLIENTS-1:0]        cli_rd, cli_wr, cli_lock, cli_en, cli_ac, cli_wait;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_wrdata;
  logic [NUM_CLIENTS*BE_W-1:0]   cli_be;
  logic [DATA_W-1:0]             cli_rddata, ar_wrdata, ar_rddata;
  logic [IW-1:0]                 grant_idx;
  logic                          busy, proto_err, ar_read, ar_write, ar_ac;
  logic [ADDR_W-1:0]             ar_addr;
  logic [BE_W-1:0]               ar_be;
  modport master (
    input  cli_rd, cli_wr, cli_lock, cli_en, cli_addr, cli_wrdata, cli_be, ar_ac, ar_rddata,
    output cli_ac, cli_wait, cli_rddata, grant_idx, busy, proto_err,
           ar_addr, ar_be, ar_read, ar_write, ar_wrdata
  );
  modport slave (
    output cli_rd, cli_wr, cli_lock, cli_en, cli_addr, cli_wrdata, cli_be, ar_ac, ar_rddata,
    input  cli_ac, cli_wait, cli_rddata, grant_idx, busy, proto_err,
           ar_addr, ar_be, ar_read, ar_write, ar_wrdata
  );
endinterface

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: high-priority-first, then round-robin winner search starting at the pointer
module rr_pick import sdram_arb_pkg::*; #(
  parameter int NUM_CLIENTS = 5,
  parameter int HP_CLIENT = 0,
  localparam int IW = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] i_elig,
  input  logic [IW-1:0]          i_ptr,
  output logic [IW-1:0]          o_win,
  output logic                   o_found
);
  logic [2*NUM_CLIENTS-1:0] w_dbl;
  logic [IW-1:0]            w_off;
  logic [IW:0]              w_sum;
  // doubling the request vector turns the wrap-around search into a plain lowest-bit search
  assign w_dbl = {i_elig, i_elig} >> i_ptr;
  always_comb begin
    w_off = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) w_off = w_dbl[k] ? IW'(k) : w_off;
  end
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_win = i_elig[HP_CLIENT] ? IW'(HP_CLIENT) :
                 (int'(w_sum) >= NUM_CLIENTS) ? IW'(int'(w_sum) - NUM_CLIENTS) : w_sum[IW-1:0];
  assign o_found = |i_elig;
endmodule

// File: rtl/sdram_arbiter_rr.sv
// sdram_arbiter_rr: round-robin N-client arbiter with HP client and bounded lock for one SDRAM port
module sdram_arbiter_rr import sdram_arb_pkg::*; #(
  parameter int NUM_CLIENTS = 5,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int HP_CLIENT = 0,
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic reset,
  sdram_arbiter_rr_if.master bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  arb_state_t             r_state;
  arb_cmd_t               r_cmd;
  logic                   r_live, r_perr;
  logic [IW-1:0]          r_gnt, r_ptr;
  logic [HW-1:0]          r_hold;
  logic [NUM_CLIENTS-1:0] r_ac, r_wait;
  logic [DATA_W-1:0]      r_rddata;
  logic [NUM_CLIENTS-1:0] w_elig;
  logic [IW-1:0]          w_win, w_sel;
  logic                   w_found, w_cli_rd, w_cli_wr, w_cont, w_load;
  arb_cmd_t               w_next;
  assign w_elig = (bus.cli_rd | bus.cli_wr) & bus.cli_en;
  rr_pick #(.NUM_CLIENTS(NUM_CLIENTS), .HP_CLIENT(HP_CLIENT)) u_pick (
    .i_elig(w_elig), .i_ptr(r_ptr), .o_win(w_win), .o_found(w_found)
  );
  // in IDLE the command comes from the new winner, in ACK from the locking owner
  assign w_sel = (r_state == IDLE) ? w_win : r_gnt;
  assign w_cli_rd = bus.cli_rd[w_sel];
  assign w_cli_wr = bus.cli_wr[w_sel];
  assign w_next = '{addr:   bus.cli_addr[w_sel*ADDR_W +: ADDR_W],
                    wrdata: bus.cli_wrdata[w_sel*DATA_W +: DATA_W],
                    be:     bus.cli_be[w_sel*BE_W +: BE_W],
                    wr:     w_cli_wr};
  assign w_cont = bus.cli_lock[r_gnt] & w_elig[r_gnt] & (int'(r_hold) < MAX_HOLD - 1);
  assign w_load = ((r_state == IDLE) & w_found) | ((r_state == ACK) & w_cont);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cmd    <= '{addr: '0, wrdata: '0, be: '1, wr: 1'b0};
      r_live   <= 1'b0;
      r_perr   <= 1'b0;
      r_gnt    <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_ac     <= '0;
      r_wait   <= '1;
      r_rddata <= '0;
    end else begin
      r_ac <= '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_gnt  <= w_win;
          r_wait <= ~(NUM_CLIENTS'(1) << w_win);
        end
        CMD: if (bus.ar_ac) begin
          r_rddata <= bus.ar_rddata;
          r_live   <= 1'b0;
          r_ac     <= NUM_CLIENTS'(1) << r_gnt;
          r_state  <= ACK;
        end
        ACK: if (w_cont) r_hold <= r_hold + 1'b1;
        else begin
          r_ptr   <= (int'(r_gnt) == NUM_CLIENTS - 1) ? '0 : r_gnt + 1'b1;
          r_hold  <= '0;
          r_wait  <= '1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_load) begin
        r_cmd   <= w_next;
        r_live  <= 1'b1;
        r_perr  <= r_perr | (w_cli_rd & w_cli_wr);
        r_state <= CMD;
      end
    end
  end
  assign bus.ar_addr    = r_cmd.addr;
  assign bus.ar_wrdata  = r_cmd.wrdata;
  assign bus.ar_be      = r_cmd.be;
  assign bus.ar_read    = r_live & ~r_cmd.wr;
  assign bus.ar_write   = r_live & r_cmd.wr;
  assign bus.cli_ac     = r_ac;
  assign bus.cli_wait   = r_wait;
  assign bus.cli_rddata = r_rddata;
  assign bus.grant_idx  = r_gnt;
  assign bus.busy       = r_state != IDLE;
  assign bus.proto_err  = r_perr;
endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// tb_sdram_arbiter_rr: directed vector table plus hand sequences for reset, round-robin and lock
module tb_sdram_arbiter_rr;
  import sdram_arb_pkg::*;
  localparam int N = 5;
  localparam int AW = 22;
  localparam int DW = 128;
  localparam int BW = DW / 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sdram_arbiter_rr_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  sdram_arbiter_rr #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .HP_CLIENT(0), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  typedef struct {
    logic [N-1:0]  rd;
    logic [N-1:0]  wr;
    logic [N-1:0]  en;
    int            g;
    logic          wr_dir;
    logic          perr;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl [8];
  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h100 | ((i ^ 2) << 16));
  endfunction
  function automatic logic [BW-1:0] be_of(input int i);
    return BW'(32'h8000 | (1 << i));
  endfunction
  function automatic logic [DW-1:0] wd_of(input int i);
    return {BW{8'(8'h10 + i)}};
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // waits for a command, holds it d cycles, acks with data and checks the ACK cycle
  task automatic serve(input int d, input logic [DW-1:0] data, output int g, output int n);
    logic [N-1:0] ew;
    n = 0;
    while (!(bus.ar_read | bus.ar_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      n_chk++;
      n_fail++;
      $display("FAIL serve_timeout: no strobe within %0d cycles", n);
      g = -1;
      return;
    end
    g = int'(bus.grant_idx);
    ew = ~(N'(1) << g);
    chk("serve_wait", bus.cli_wait, ew);
    for (int k = 1; k < d; k++) begin
      @(posedge clk); #1;
      chk("serve_held", bus.ar_read | bus.ar_write, 1);
      chk("serve_addr", bus.ar_addr, addr_of(g));
      chk("serve_ac_early", bus.cli_ac, 0);
    end
    bus.ar_ac = 1'b1;
    bus.ar_rddata = data;
    @(posedge clk); #1;
    bus.ar_ac = 1'b0;
    bus.ar_rddata = '0;
    chk("serve_cli_ac", bus.cli_ac, N'(1) << g);
    chk("serve_rddata", bus.cli_rddata, data);
    chk("serve_strobe_drop", {bus.ar_read, bus.ar_write}, 0);
    chk("serve_busy_ack", bus.busy, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int g, n;
    int rr_exp [5];
    bus.cli_rd = '0;
    bus.cli_wr = '0;
    bus.cli_lock = '0;
    bus.cli_en = '1;
    bus.ar_ac = 1'b0;
    bus.ar_rddata = '0;
    for (int i = 0; i < N; i++) begin
      bus.cli_addr[i*AW +: AW] = addr_of(i);
      bus.cli_wrdata[i*DW +: DW] = wd_of(i);
      bus.cli_be[i*BW +: BW] = be_of(i);
    end
    tbl[0] = '{5'b00100, 5'b00000, 5'b11111, 2, 1'b0, 1'b0, {BW{8'hA5}}};
    tbl[1] = '{5'b10010, 5'b00000, 5'b11111, 4, 1'b0, 1'b0, {BW{8'h3C}}};
    tbl[2] = '{5'b10010, 5'b00000, 5'b11111, 1, 1'b0, 1'b0, {BW{8'h69}}};
    tbl[3] = '{5'b01000, 5'b00000, 5'b10111, -1, 1'b0, 1'b0, '0};
    tbl[4] = '{5'b01001, 5'b00000, 5'b11111, 0, 1'b0, 1'b0, {BW{8'h0F}}};
    tbl[5] = '{5'b11000, 5'b00000, 5'b11111, 3, 1'b0, 1'b0, {BW{8'hC3}}};
    tbl[6] = '{5'b00100, 5'b00100, 5'b11111, 2, 1'b1, 1'b1, {BW{8'h11}}};
    tbl[7] = '{5'b00000, 5'b00010, 5'b11111, 1, 1'b1, 1'b1, {BW{8'h22}}};
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", bus.cli_wait, {N{1'b1}});
    chk("rst_be", bus.ar_be, {BW{1'b1}});
    chk("rst_strobes", {bus.ar_read, bus.ar_write}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ac", bus.cli_ac, 0);
    chk("rst_grant", bus.grant_idx, 0);
    chk("rst_perr", bus.proto_err, 0);
    chk("rst_addr", bus.ar_addr, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 8; t++) begin
      bus.cli_rd = tbl[t].rd;
      bus.cli_wr = tbl[t].wr;
      bus.cli_en = tbl[t].en;
      @(posedge clk); #1;
      if (tbl[t].g < 0) begin
        chk("mask_busy", bus.busy, 0);
        chk("mask_wait", bus.cli_wait, {N{1'b1}});
        @(posedge clk); #1;
        chk("mask_busy2", bus.busy, 0);
        bus.cli_rd = '0;
        bus.cli_wr = '0;
        bus.cli_en = '1;
        @(posedge clk); #1;
      end else begin
        chk("vec_grant", bus.grant_idx, tbl[t].g);
        chk("vec_read", bus.ar_read, !tbl[t].wr_dir);
        chk("vec_write", bus.ar_write, tbl[t].wr_dir);
        chk("vec_addr", bus.ar_addr, addr_of(tbl[t].g));
        chk("vec_be", bus.ar_be, be_of(tbl[t].g));
        if (tbl[t].wr_dir) chk("vec_wrdata", bus.ar_wrdata, wd_of(tbl[t].g));
        chk("vec_perr", bus.proto_err, tbl[t].perr);
        bus.cli_rd = '0;
        bus.cli_wr = '0;
        serve(3, tbl[t].data, g, n);
        chk("vec_serve_grant", g, tbl[t].g);
        chk("vec_serve_lat", n, 0);
        @(posedge clk); #1;
        chk("vec_idle_busy", bus.busy, 0);
        chk("vec_idle_wait", bus.cli_wait, {N{1'b1}});
        chk("vec_idle_ac", bus.cli_ac, 0);
        chk("vec_perr_sticky", bus.proto_err, tbl[t].perr);
      end
    end
    bus.cli_rd = 5'b00100;
    @(posedge clk); #1;
    chk("midrst_grant", bus.grant_idx, 2);
    chk("midrst_read", bus.ar_read, 1);
    reset = 1'b0;
    #1;
    chk("midrst_read_drop", bus.ar_read, 0);
    chk("midrst_wait", bus.cli_wait, {N{1'b1}});
    chk("midrst_be", bus.ar_be, {BW{1'b1}});
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_perr", bus.proto_err, 0);
    chk("midrst_rddata", bus.cli_rddata, 0);
    bus.cli_rd = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.cli_rd = 5'b01010;
    serve(1, {BW{8'h5A}}, g, n);
    chk("postrst_grant", g, 1);
    chk("postrst_lat", n, 1);
    bus.cli_rd = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    rr_exp = '{1, 3, 4, 1, 3};
    bus.cli_rd = 5'b11010;
    for (int k = 0; k < 5; k++) begin
      serve(1, {BW{8'(k)}}, g, n);
      chk("rr_grant", g, rr_exp[k]);
      chk("rr_bubble", n, (k == 0) ? 1 : 2);
    end
    bus.cli_rd = '0;
    @(posedge clk); #1;
    chk("rr_idle", bus.busy, 0);
    bus.cli_rd = 5'b00010;
    bus.cli_lock = 5'b00010;
    @(posedge clk); #1;
    chk("lock_first_grant", bus.grant_idx, 1);
    chk("lock_first_read", bus.ar_read, 1);
    bus.cli_rd = 5'b00011;
    for (int k = 0; k < 8; k++) begin
      serve(2, {BW{8'(8'h80 + k)}}, g, n);
      chk("lock_grant", g, 1);
      chk("lock_lat", n, (k == 0) ? 0 : 1);
    end
    serve(1, {BW{8'hEE}}, g, n);
    chk("lock_hp_grant", g, 0);
    chk("lock_hp_bubble", n, 2);
    bus.cli_rd = '0;
    bus.cli_lock = '0;
    @(posedge clk); #1;
    chk("end_idle", bus.busy, 0);
    chk("end_perr", bus.proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
